// File: rtl/mux_sel_scheduler.sv
// Select scheduler for the 5-input bit-serial mux: turns a per-group nonzero mask
// into one (sel, val) beat per set bit, lowest index first.
module mux_sel_scheduler #(
  parameter int NUM_IN    = 5,
  parameter int SEL_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_IN-1:0]    mask_in,
  input  logic                 mask_valid,
  output logic                 mask_ready,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SEL_WIDTH-1:0] sel_out,
  output logic                 val_out,
  output logic                 last_out,
  output logic                 busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_ISSUE = 1'b1;

  logic [0:0]           state_q, state_d;
  logic [NUM_IN-1:0]    rem_q, rem_d;
  logic [NUM_IN-1:0]    low_bit;
  logic [SEL_WIDTH-1:0] low_idx;
  logic                 issue, fire, accept, at_most_one;

  assign issue       = (state_q == ST_ISSUE);
  assign low_bit     = rem_q & (~rem_q + NUM_IN'(1));
  // Clearing the lowest bit leaves nothing when zero or one bit remains.
  assign at_most_one = ((rem_q & (rem_q - NUM_IN'(1))) == '0);

  always_comb begin
    low_idx = '0;
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (rem_q[i]) low_idx = SEL_WIDTH'(i);
    end
  end

  assign out_valid  = issue;
  assign busy       = issue;
  assign sel_out    = issue ? low_idx : '0;
  assign val_out    = issue && (rem_q != '0);
  assign last_out   = issue && at_most_one;
  assign fire       = issue && out_ready;
  assign mask_ready = !issue || (fire && last_out);
  assign accept     = mask_valid && mask_ready;

  // A new mask accepted on the final beat overrides the return to IDLE.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    if (fire) rem_d = rem_q & ~low_bit;
    if (fire && last_out) state_d = ST_IDLE;
    if (accept) begin
      state_d = ST_ISSUE;
      rem_d   = mask_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

endmodule

// File: tb/tb_mux_sel_scheduler.sv
// Bench for mux_sel_scheduler: directed scenarios plus random masks against a beat-queue model.
module tb_mux_sel_scheduler;

  localparam int NUM_IN    = 5;
  localparam int SEL_WIDTH = 3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_IN-1:0]    mask_in;
  logic                 mask_valid;
  logic                 mask_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [SEL_WIDTH-1:0] sel_out;
  logic                 val_out;
  logic                 last_out;
  logic                 busy;

  mux_sel_scheduler #(.NUM_IN(NUM_IN), .SEL_WIDTH(SEL_WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .mask_in    (mask_in),
    .mask_valid (mask_valid),
    .mask_ready (mask_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .sel_out    (sel_out),
    .val_out    (val_out),
    .last_out   (last_out),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [SEL_WIDTH-1:0] sel;
    logic                 val;
    logic                 last;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks  = 0;
  int    n_fail    = 0;
  int    beat_cnt  = 0;
  bit    stall_prev = 1'b0;
  logic [SEL_WIDTH+1:0] held;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected beats for one mask: ascending set-bit indices, or one val=0 beat.
  task automatic push_mask(input logic [NUM_IN-1:0] m);
    int total, seen;
    beat_t b;
    total = 0;
    for (int i = 0; i < NUM_IN; i++) total += int'(m[i]);
    if (total == 0) begin
      b.sel = '0; b.val = 1'b0; b.last = 1'b1;
      exp_q.push_back(b);
    end else begin
      seen = 0;
      for (int i = 0; i < NUM_IN; i++) begin
        if (m[i]) begin
          seen++;
          b.sel = SEL_WIDTH'(i); b.val = 1'b1; b.last = (seen == total);
          exp_q.push_back(b);
        end
      end
    end
  endtask

  always @(negedge clk) begin
    beat_t b;
    if (reset) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      chk("val_without_valid", {31'b0, val_out & ~out_valid}, 32'd0);
      chk("sel_range", {31'b0, (int'(sel_out) < NUM_IN)}, 32'd1);
      if (stall_prev) chk("backpressure_hold", {27'b0, sel_out, val_out, last_out}, {27'b0, held});
      if (mask_valid && mask_ready) push_mask(mask_in);
      if (out_valid && out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'd1, 32'd0);
        end else begin
          b = exp_q.pop_front();
          chk("beat_sel", {29'b0, sel_out}, {29'b0, b.sel});
          chk("beat_val", {31'b0, val_out}, {31'b0, b.val});
          chk("beat_last", {31'b0, last_out}, {31'b0, b.last});
        end
      end
      stall_prev = out_valid && !out_ready;
      held = {sel_out, val_out, last_out};
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the beat currently presented (out_ready assumed high) then advances a cycle.
  task automatic expect_beat(input string tag, input int sel, input bit val, input bit last);
    @(negedge clk);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({tag, "_sel"}, {29'b0, sel_out}, sel);
    chk({tag, "_val"}, {31'b0, val_out}, {31'b0, val});
    chk({tag, "_last"}, {31'b0, last_out}, {31'b0, last});
    chk({tag, "_mready"}, {31'b0, mask_ready}, {31'b0, last});
    tick();
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    chk({tag, "_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_busy"}, {31'b0, busy}, 32'd0);
    chk({tag, "_mready"}, {31'b0, mask_ready}, 32'd1);
  endtask

  task automatic send_mask(input logic [NUM_IN-1:0] m);
    mask_in = m;
    mask_valid = 1'b1;
    tick();
    mask_valid = 1'b0;
  endtask

  initial begin
    int sent, guard, exp_sum, beat_start, pc;
    bit acc;
    reset = 1'b1; mask_in = '0; mask_valid = 1'b0; out_ready = 1'b0;
    repeat (3) tick();
    reset = 1'b0;

    @(negedge clk);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_sel", {29'b0, sel_out}, 32'd0);
    chk("rst_val", {31'b0, val_out}, 32'd0);
    chk("rst_last", {31'b0, last_out}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_mready", {31'b0, mask_ready}, 32'd1);
    tick();

    out_ready = 1'b1;
    send_mask(5'b10110);
    expect_beat("t1_b0", 1, 1'b1, 1'b0);
    expect_beat("t1_b1", 2, 1'b1, 1'b0);
    expect_beat("t1_b2", 4, 1'b1, 1'b1);
    expect_idle("t1_end");
    tick();

    send_mask(5'b00000);
    expect_beat("t2_zero", 0, 1'b0, 1'b1);
    expect_idle("t2_end");
    tick();

    mask_in = 5'b11111; mask_valid = 1'b1;
    tick();
    mask_in = 5'b00001;
    for (int i = 0; i < 5; i++) expect_beat("t3_a", i, 1'b1, (i == 4));
    mask_valid = 1'b0;
    expect_beat("t3_b", 0, 1'b1, 1'b1);
    expect_idle("t3_end");
    tick();

    send_mask(5'b01001);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4_stall_valid", {31'b0, out_valid}, 32'd1);
      chk("t4_stall_sel", {29'b0, sel_out}, 32'd0);
      chk("t4_stall_val", {31'b0, val_out}, 32'd1);
      chk("t4_stall_last", {31'b0, last_out}, 32'd0);
      chk("t4_stall_mready", {31'b0, mask_ready}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    expect_beat("t4_b0", 0, 1'b1, 1'b0);
    expect_beat("t4_b1", 3, 1'b1, 1'b1);
    expect_idle("t4_end");
    tick();

    send_mask(5'b11100);
    expect_beat("t5_b0", 2, 1'b1, 1'b0);
    reset = 1'b1;
    #1;
    chk("t5_async_valid", {31'b0, out_valid}, 32'd0);
    chk("t5_async_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    tick();
    reset = 1'b0;
    expect_idle("t5_post0");
    tick();
    expect_idle("t5_post1");
    tick();
    send_mask(5'b00010);
    expect_beat("t5_new", 1, 1'b1, 1'b1);
    expect_idle("t5_end");
    tick();

    sent = 0; guard = 0; exp_sum = 0; beat_start = beat_cnt;
    mask_in = ($urandom_range(0, 3) == 0) ? '0 : NUM_IN'($urandom);
    mask_valid = 1'b1;
    while (sent < 1000 && guard < 60000) begin
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = mask_valid && mask_ready;
      if (acc) begin
        pc = 0;
        for (int i = 0; i < NUM_IN; i++) pc += int'(mask_in[i]);
        exp_sum += (pc == 0) ? 1 : pc;
      end
      tick();
      guard++;
      if (acc) begin
        sent++;
        mask_in = ($urandom_range(0, 3) == 0) ? '0 : NUM_IN'($urandom);
        mask_valid = ($urandom_range(0, 4) != 0);
      end else if (!mask_valid) begin
        mask_valid = 1'($urandom_range(0, 1));
      end
    end
    chk("rand_masks_sent", sent, 32'd1000);
    mask_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while ((out_valid || exp_q.size() != 0) && guard < 200) begin
      tick();
      guard++;
    end
    @(negedge clk);
    chk("rand_drain_valid", {31'b0, out_valid}, 32'd0);
    chk("rand_drain_queue", exp_q.size(), 32'd0);
    chk("rand_beat_count", beat_cnt - beat_start, exp_sum);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mux_sel_scheduler.md
Name: mux_sel_scheduler

Overview:
- Producer end of the sel/val interface consumed by the 5-input select mux in the bit-serial datapath.
- Accepts a per-group nonzero mask (one bit per mux input) through a valid/ready handshake.
- Emits one mux select per cycle for each set bit, in ascending index order, with val asserted.
- An all-zero mask produces a single beat with val deasserted, so the downstream mux outputs zero.

Parameters:
- NUM_IN, 5, number of mux inputs / mask width (legal range 2..8).
- SEL_WIDTH, 3, select width; must equal ceil(log2(NUM_IN)).

Ports:
- clk  input  1  clock, all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- mask_in  input  NUM_IN  nonzero flags; bit i set means mux input i must be issued.
- mask_valid  input  1  mask_in is valid this cycle.
- mask_ready  output  1  scheduler can accept a mask this cycle.
- out_valid  output  1  a select beat is presented.
- out_ready  input  1  downstream consumes the beat this cycle.
- sel_out  output  SEL_WIDTH  mux select index.
- val_out  output  1  mux val; 0 means the mux must output zero.
- last_out  output  1  final beat of the current mask.
- busy  output  1  high while in the ISSUE state.

Behaviour:
- Reset: state=IDLE, remaining mask register=0, out_valid=0, sel_out=0, val_out=0, last_out=0, busy=0.
  - mask_ready=1 as soon as reset deasserts.
  - Reset asserted mid-operation discards the remaining bits immediately, with no further beats.
- States: IDLE and ISSUE.
  - IDLE: out_valid=0. If mask_valid, latch mask_in into the remaining register and go to ISSUE.
  - ISSUE: out_valid=1. sel_out = index of the lowest set bit of the remaining register.
    - val_out=1 and last_out = (popcount(remaining)==1).
    - On out_ready: clear that bit. If last_out, go to IDLE unless a new mask is accepted in the same cycle.
  - Zero mask in ISSUE: one beat with sel_out=0, val_out=0, last_out=1. Consumed by out_ready; nothing further is issued for it.
- mask_ready = (state==IDLE) OR (out_valid AND out_ready AND last_out). This is the only combinational input-to-output path.
- Back-to-back masks:
  - When the final beat is consumed in the same cycle a new mask is accepted, the state stays ISSUE.
  - The next mask's first beat appears on the following cycle, with no bubble.
- Latency: mask accepted on cycle N, first beat presented on cycle N+1.
  - A mask with k>0 set bits occupies exactly k beats when out_ready is held high.
- Backpressure: while out_valid=1 and out_ready=0, sel_out/val_out/last_out hold stable and the remaining register does not change.
- mask_in is sampled only on the accepting edge. Changes while mask_ready=0 are ignored.
- sel_out/val_out/last_out are registered or derived only from registered state, never from mask_in in the same cycle.
- sel_out is always < NUM_IN. val_out=1 never occurs with out_valid=0.

Test Plan:
- Reset, then mask_in=5'b10110, mask_valid pulse, out_ready=1 -> beats sel=1,2,4 on cycles N+1..N+3, val=1 throughout, last_out only with sel=4; then IDLE, mask_ready=1.
- mask_in=5'b00000 -> exactly one beat: sel=0, val=0, last=1; busy drops the next cycle.
- mask 5'b11111 followed immediately by mask 5'b00001 held valid, out_ready=1 -> sel 0,1,2,3,4 then sel 0 with no idle cycle; second mask accepted on the same cycle as sel=4/last.
- mask 5'b01001, out_ready low for 3 cycles on the first beat -> sel=0 held stable with val=1, last=0 for 3 cycles; then sel=3, last=1.
- Assert reset during the second beat of 5'b11100 -> out_valid=0 immediately (async); after release no further beats; mask_ready=1; a new mask 5'b00010 yields a single beat with sel=1.
- Random masks with random out_ready, 1000 masks -> beat sequence equals ascending set-bit indices per mask (single val=0 beat for zero masks); beat count = sum(max(popcount,1)).
